// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Packs decoded RV32I instruction fields into legal 32-bit
//            instruction words and writes them to instruction memory at
//            consecutive word addresses. Immediates are range-checked and
//            illegal field combinations are rejected with an error code.
// Ports    : i_clk, i_reset (sync, active-low)
//            start/base_addr          - begin a program at base_addr
//            req_* (valid/ready)      - decoded instruction request stream
//            mem_wren/addr/wdata      - instruction memory write port
//            err_valid/code/cnt       - rejection pulse, reason, sat. count
//            busy/done/full           - program status
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_fmt,
  input  logic [2:0]           req_funct3,
  input  logic                 req_alt,
  input  logic [4:0]           req_rd,
  input  logic [4:0]           req_rs1,
  input  logic [4:0]           req_rs2,
  input  logic [31:0]          req_imm,
  input  logic                 req_last,
  output logic                 mem_wren,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy,
  output logic                 done,
  output logic                 full
);

  localparam logic [3:0] C_FMT_R     = 4'd0;
  localparam logic [3:0] C_FMT_I     = 4'd1;
  localparam logic [3:0] C_FMT_IL    = 4'd2;
  localparam logic [3:0] C_FMT_S     = 4'd3;
  localparam logic [3:0] C_FMT_B     = 4'd4;
  localparam logic [3:0] C_FMT_JAL   = 4'd5;
  localparam logic [3:0] C_FMT_JALR  = 4'd6;
  localparam logic [3:0] C_FMT_LUI   = 4'd7;
  localparam logic [3:0] C_FMT_AUIPC = 4'd8;

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_I      = 7'b0010011;
  localparam logic [6:0] C_OP_IL     = 7'b0000011;
  localparam logic [6:0] C_OP_S      = 7'b0100011;
  localparam logic [6:0] C_OP_B      = 7'b1100011;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;

  localparam logic [ADDR_W-1:0]    C_TOP_ADDR = '1;
  localparam logic [ERR_CNT_W-1:0] C_ERR_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [ADDR_W-1:0]      r_addr;
  logic                   r_mem_wren;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic [31:0]            r_mem_wdata;
  logic                   r_err_valid;
  logic [1:0]             r_err_code;
  logic [ERR_CNT_W-1:0]   r_err_cnt;
  logic                   r_full;
  logic                   r_fin;   // program ended at this edge; done follows
  logic                   r_done;

  logic        w_imm_s12, w_imm_s13, w_imm_s21, w_imm_u5;
  logic        w_bad_fn, w_misal, w_range;
  logic [6:0]  w_funct7;
  logic [31:0] w_word;
  logic [1:0]  w_code;
  logic        w_accept, w_ok;

  // Signed-fit tests: all bits above the sign bit must replicate it.
  assign w_imm_s12 = (req_imm[31:11] == {21{req_imm[11]}});
  assign w_imm_s13 = (req_imm[31:12] == {20{req_imm[12]}});
  assign w_imm_s21 = (req_imm[31:20] == {12{req_imm[20]}});
  assign w_imm_u5  = (req_imm[31:5]  == 27'd0);
  assign w_funct7  = req_alt ? 7'b0100000 : 7'b0000000;

  always_comb begin
    w_bad_fn = 1'b0;
    w_misal  = 1'b0;
    w_range  = 1'b0;
    w_word   = '0;
    case (req_fmt)
      C_FMT_R: begin
        w_bad_fn = req_alt && (req_funct3 != 3'b000) && (req_funct3 != 3'b101);
        w_word   = {w_funct7, req_rs2, req_rs1, req_funct3, req_rd, C_OP_R};
      end
      C_FMT_I: begin
        // Shifts carry a 5-bit shamt plus funct7; other ALU ops a full imm12.
        if ((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) begin
          w_bad_fn = req_alt && (req_funct3 == 3'b001);
          w_range  = !w_imm_u5;
          w_word   = {w_funct7, req_imm[4:0], req_rs1, req_funct3, req_rd, C_OP_I};
        end else begin
          w_range  = !w_imm_s12;
          w_word   = {req_imm[11:0], req_rs1, req_funct3, req_rd, C_OP_I};
        end
      end
      C_FMT_IL: begin
        w_bad_fn = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                   (req_funct3 == 3'b111);
        w_range  = !w_imm_s12;
        w_word   = {req_imm[11:0], req_rs1, req_funct3, req_rd, C_OP_IL};
      end
      C_FMT_S: begin
        w_bad_fn = req_funct3[2] || (req_funct3 == 3'b011);
        w_range  = !w_imm_s12;
        w_word   = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], C_OP_S};
      end
      C_FMT_B: begin
        w_bad_fn = (req_funct3 == 3'b010) || (req_funct3 == 3'b011);
        w_misal  = req_imm[0];
        w_range  = !w_imm_s13;
        w_word   = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                    req_imm[4:1], req_imm[11], C_OP_B};
      end
      C_FMT_JAL: begin
        w_misal  = req_imm[0];
        w_range  = !w_imm_s21;
        w_word   = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                    req_rd, C_OP_JAL};
      end
      C_FMT_JALR: begin
        w_bad_fn = (req_funct3 != 3'b000);
        w_range  = !w_imm_s12;
        w_word   = {req_imm[11:0], req_rs1, 3'b000, req_rd, C_OP_JALR};
      end
      C_FMT_LUI: begin
        w_range  = (req_imm[11:0] != 12'd0);
        w_word   = {req_imm[31:12], req_rd, C_OP_LUI};
      end
      C_FMT_AUIPC: begin
        w_range  = (req_imm[11:0] != 12'd0);
        w_word   = {req_imm[31:12], req_rd, C_OP_AUIPC};
      end
      default: w_bad_fn = 1'b1;
    endcase
  end

  // Priority: bad format/funct, then misalignment, then range.
  assign w_code   = w_bad_fn ? 2'd1 : (w_misal ? 2'd3 : (w_range ? 2'd2 : 2'd0));
  assign w_ok     = (w_code == 2'd0);
  assign w_accept = req_valid && (r_state == S_RUN);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_mem_wren  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= 2'd0;
      r_err_cnt   <= '0;
      r_full      <= 1'b0;
      r_fin       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mem_wren  <= 1'b0;
      r_err_valid <= 1'b0;
      r_fin       <= 1'b0;
      r_done      <= r_fin;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_addr  <= base_addr;
          end
        end
        S_RUN: begin
          if (w_accept) begin
            if (w_ok) begin
              r_mem_wren  <= 1'b1;
              r_mem_addr  <= r_addr;
              r_mem_wdata <= w_word;
              // Address saturates at the top; that write also ends the program.
              if (r_addr != C_TOP_ADDR) r_addr <= r_addr + ADDR_W'(1);
              else                      r_full <= 1'b1;
            end else begin
              r_err_valid <= 1'b1;
              r_err_code  <= w_code;
              if (r_err_cnt != C_ERR_MAX) r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
            if (req_last || (w_ok && (r_addr == C_TOP_ADDR))) begin
              r_state <= S_DONE;
              r_fin   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (start) begin
            r_state <= S_RUN;
            r_addr  <= base_addr;
            r_full  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_RUN);
  assign busy      = (r_state == S_RUN);
  assign mem_wren  = r_mem_wren;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err_valid = r_err_valid;
  assign err_code  = r_err_code;
  assign err_cnt   = r_err_cnt;
  assign done      = r_done;
  assign full      = r_full;

endmodule
`default_nettype wire
